butterfly_pair_serializer: RTL and testbench

Recombines the two parallel complex results of a radix-2 butterfly stage (upper/lower pair) into a single serial complex sample stream, one sample per accepted cycle, upper element first. Sits between a butterfly stage and the next serial consumer, such as the next stage's pair splitter or the output reorder buffer. Bursts of pairs are absorbed in a small pair FIFO. The serial output supports backpressure through `out_ready`.

---
 rtl/fft_pkg.sv | 13 +
 rtl/butterfly_pair_serializer_if.sv | 27 ++
 rtl/pair_fifo.sv | 49 ++++
 rtl/butterfly_pair_serializer.sv | 126 ++++++++++++
 tb/tb_butterfly_pair_serializer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared FFT pipeline definitions: output-serializer FSM encoding and pair record layout.
package fft_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFirst  = 2'd1,
    StSecond = 2'd2
  } ser_state_e;

  // A butterfly pair record is {re1, im1, re2, im2}, each field bit_width wide.
  localparam int unsigned PairFields = 4;

endpackage

// File: rtl/butterfly_pair_serializer_if.sv
// Pair input and serial output bundle of the butterfly pair serializer.
interface butterfly_pair_serializer_if #(
  parameter int unsigned bit_width = 16
);
  logic signed [bit_width-1:0] Re_i1;
  logic signed [bit_width-1:0] Im_i1;
  logic signed [bit_width-1:0] Re_i2;
  logic signed [bit_width-1:0] Im_i2;
  logic                        in_valid;
  logic                        in_ready;
  logic signed [bit_width-1:0] Re_o;
  logic signed [bit_width-1:0] Im_o;
  logic                        out_valid;
  logic                        out_second;
  logic                        out_ready;
  logic                        overflow;

  modport master (
    output Re_i1, Im_i1, Re_i2, Im_i2, in_valid, out_ready,
    input  in_ready, Re_o, Im_o, out_valid, out_second, overflow
  );

  modport slave (
    input  Re_i1, Im_i1, Re_i2, Im_i2, in_valid, out_ready,
    output in_ready, Re_o, Im_o, out_valid, out_second, overflow
  );
endinterface

// File: rtl/pair_fifo.sv
// Synchronous FIFO for butterfly pairs; full/empty decoded from the registered count.
module pair_fifo #(
  parameter int unsigned width = 64,
  parameter int unsigned depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [width-1:0] wdata,
  input  logic             pop,
  output logic [width-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int unsigned PtrW = $clog2(depth);

  logic [width-1:0] mem_q [depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (PtrW + 1)'(depth));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/butterfly_pair_serializer.sv
// Serializes buffered butterfly pairs into one complex sample per accepted cycle, upper first.
module butterfly_pair_serializer
  import fft_pkg::*;
#(
  parameter int unsigned bit_width  = 16,
  parameter int unsigned fifo_depth = 4
) (
  input logic                        clk,
  input logic                        rst_n,
  butterfly_pair_serializer_if.slave bus
);
  // Pair record kept local so its field width can follow bit_width.
  typedef struct packed {
    logic signed [bit_width-1:0] re1;
    logic signed [bit_width-1:0] im1;
    logic signed [bit_width-1:0] re2;
    logic signed [bit_width-1:0] im2;
  } pair_t;

  pair_t                       in_pair, head, pair_q, pair_d;
  logic                        fifo_full, fifo_empty, pop;
  ser_state_e                  state_q, state_d;
  logic signed [bit_width-1:0] re_q, re_d, im_q, im_d;
  logic                        valid_q, valid_d, second_q, second_d;
  logic                        overflow_q, overflow_d;

  assign in_pair = '{re1: bus.Re_i1, im1: bus.Im_i1, re2: bus.Re_i2, im2: bus.Im_i2};

  pair_fifo #(
    .width(PairFields * bit_width),
    .depth(fifo_depth)
  ) u_pair_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (bus.in_valid),
    .wdata(in_pair),
    .pop  (pop),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    pair_d   = pair_q;
    re_d     = re_q;
    im_d     = im_q;
    valid_d  = valid_q;
    second_d = second_q;
    pop      = 1'b0;
    case (state_q)
      StIdle: begin
        valid_d = 1'b0;
        if (!fifo_empty) begin
          pop      = 1'b1;
          pair_d   = head;
          re_d     = head.re1;
          im_d     = head.im1;
          valid_d  = 1'b1;
          second_d = 1'b0;
          state_d  = StFirst;
        end
      end
      StFirst: begin
        if (bus.out_ready) begin
          re_d     = pair_q.re2;
          im_d     = pair_q.im2;
          second_d = 1'b1;
          state_d  = StSecond;
        end
      end
      StSecond: begin
        if (bus.out_ready) begin
          // Chain straight into the next pair to keep one sample per cycle.
          if (!fifo_empty) begin
            pop      = 1'b1;
            pair_d   = head;
            re_d     = head.re1;
            im_d     = head.im1;
            second_d = 1'b0;
            state_d  = StFirst;
          end else begin
            valid_d  = 1'b0;
            second_d = 1'b0;
            state_d  = StIdle;
          end
        end
      end
      default: begin
        valid_d  = 1'b0;
        second_d = 1'b0;
        state_d  = StIdle;
      end
    endcase
  end

  assign overflow_d = overflow_q | (bus.in_valid & fifo_full);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pair_q     <= '0;
      re_q       <= '0;
      im_q       <= '0;
      valid_q    <= 1'b0;
      second_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pair_q     <= pair_d;
      re_q       <= re_d;
      im_q       <= im_d;
      valid_q    <= valid_d;
      second_q   <= second_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.in_ready   = ~fifo_full;
  assign bus.Re_o       = re_q;
  assign bus.Im_o       = im_q;
  assign bus.out_valid  = valid_q;
  assign bus.out_second = second_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_butterfly_pair_serializer.sv
// Bench for butterfly_pair_serializer: directed scenarios plus randomized traffic vs a sample queue.
module tb_butterfly_pair_serializer;
  localparam int unsigned W = 16;
  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  butterfly_pair_serializer_if #(.bit_width(W)) bus ();

  butterfly_pair_serializer #(
    .bit_width (W),
    .fifo_depth(D)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
    logic                second;
  } samp_t;

  samp_t exp_q[$];
  samp_t prev;
  int    n_checks = 0;
  int    n_pass = 0;
  int    n_hs = 0;
  logic  drv_accept = 1'b1;
  logic  ovf_model = 1'b0;
  logic  hold_prev = 1'b0;

  function automatic void check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b, expected %0b", name, act, exp);
  endfunction

  function automatic void check_val(input string name, input logic signed [W-1:0] act,
                                    input logic signed [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endfunction

  function automatic void check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [31:0] r;
    r = $urandom();
    return r[W-1:0];
  endfunction

  // Reference: every accepted pair contributes (upper, lower) to a flat sample queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      ovf_model = 1'b0;
      hold_prev = 1'b0;
      check_bit("rst_out_valid", bus.out_valid, 1'b0);
      check_bit("rst_in_ready", bus.in_ready, 1'b1);
      check_bit("rst_overflow", bus.overflow, 1'b0);
    end else begin
      check_bit("overflow", bus.overflow, ovf_model);
      if (bus.in_valid) begin
        check_bit("in_ready", bus.in_ready, drv_accept);
        if (!drv_accept) ovf_model = 1'b1;
      end
      if (hold_prev) begin
        check_bit("hold_valid", bus.out_valid, 1'b1);
        check_val("hold_re", bus.Re_o, prev.re);
        check_val("hold_im", bus.Im_o, prev.im);
        check_bit("hold_second", bus.out_second, prev.second);
      end
      if (bus.out_valid) begin
        check_bit("sample_expected", logic'(exp_q.size() > 0), 1'b1);
        if (exp_q.size() > 0) begin
          check_val("re", bus.Re_o, exp_q[0].re);
          check_val("im", bus.Im_o, exp_q[0].im);
          check_bit("second", bus.out_second, exp_q[0].second);
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            n_hs++;
          end
        end
      end
      hold_prev   = bus.out_valid && !bus.out_ready;
      prev.re     = bus.Re_o;
      prev.im     = bus.Im_o;
      prev.second = bus.out_second;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic signed [W-1:0] r1, input logic signed [W-1:0] i1,
                      input logic signed [W-1:0] r2, input logic signed [W-1:0] i2,
                      input logic acc);
    samp_t s;
    bus.Re_i1    = r1;
    bus.Im_i1    = i1;
    bus.Re_i2    = r2;
    bus.Im_i2    = i2;
    bus.in_valid = 1'b1;
    drv_accept   = acc;
    if (acc) begin
      s = '{re: r1, im: i1, second: 1'b0};
      exp_q.push_back(s);
      s = '{re: r2, im: i2, second: 1'b1};
      exp_q.push_back(s);
    end
    tick(1);
    bus.in_valid = 1'b0;
    drv_accept   = 1'b1;
  endtask

  initial begin
    int hs0;
    int sent;
    int cyc;
    bus.Re_i1     = '0;
    bus.Im_i1     = '0;
    bus.Re_i2     = '0;
    bus.Im_i2     = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick(2);
    rst_n = 1'b1;
    check_bit("reset_valid", bus.out_valid, 1'b0);
    check_bit("reset_second", bus.out_second, 1'b0);
    check_val("reset_re", bus.Re_o, 16'sd0);
    check_val("reset_im", bus.Im_o, 16'sd0);
    check_bit("reset_in_ready", bus.in_ready, 1'b1);

    // Single pair latency.
    send(16'sd1000, -16'sd1000, 16'sd2000, -16'sd2000, 1'b1);
    check_bit("single_t0_valid", bus.out_valid, 1'b0);
    tick(1);
    check_bit("single_t1_valid", bus.out_valid, 1'b1);
    check_val("single_t1_re", bus.Re_o, 16'sd1000);
    check_val("single_t1_im", bus.Im_o, -16'sd1000);
    check_bit("single_t1_second", bus.out_second, 1'b0);
    tick(1);
    check_val("single_t2_re", bus.Re_o, 16'sd2000);
    check_val("single_t2_im", bus.Im_o, -16'sd2000);
    check_bit("single_t2_second", bus.out_second, 1'b1);
    tick(1);
    check_bit("single_t3_valid", bus.out_valid, 1'b0);

    // Four back-to-back pairs must stream out as 8 contiguous samples.
    hs0 = n_hs;
    for (int k = 0; k < 4; k++) begin
      send(16'(10 * k + 1), 16'(10 * k + 2), 16'(10 * k + 3), 16'(10 * k + 4), 1'b1);
    end
    check_bit("burst_valid_mid", bus.out_valid, 1'b1);
    tick(6);
    check_int("burst_samples", n_hs - hs0, 8);
    check_bit("burst_done_valid", bus.out_valid, 1'b0);
    check_bit("burst_overflow", bus.overflow, 1'b0);

    // Backpressure on an upper element.
    bus.out_ready = 1'b0;
    send(16'sd3, 16'sd4, 16'sd5, 16'sd6, 1'b1);
    tick(4);
    check_bit("bp_valid", bus.out_valid, 1'b1);
    check_val("bp_re", bus.Re_o, 16'sd3);
    check_bit("bp_second", bus.out_second, 1'b0);
    bus.out_ready = 1'b1;
    tick(3);
    check_bit("bp_drained_valid", bus.out_valid, 1'b0);
    check_int("bp_queue_empty", exp_q.size(), 0);

    // Overflow: one pair parked in the output register, then 4 fill the FIFO, 5th is dropped.
    bus.out_ready = 1'b0;
    send(-16'sd7, 16'sd7, -16'sd8, 16'sd8, 1'b1);
    tick(1);
    for (int k = 0; k < 5; k++) begin
      send(16'(100 + k), 16'(200 + k), 16'(300 + k), 16'(400 + k), logic'(k < 4));
    end
    check_bit("ovf_set", bus.overflow, 1'b1);
    check_bit("ovf_in_ready", bus.in_ready, 1'b0);
    hs0 = n_hs;
    bus.out_ready = 1'b1;
    tick(12);
    check_int("ovf_drained", n_hs - hs0, 10);
    check_bit("ovf_sticky", bus.overflow, 1'b1);
    check_bit("ovf_done_valid", bus.out_valid, 1'b0);

    // Reset with the lower element showing and two pairs buffered.
    bus.out_ready = 1'b0;
    send(16'sd11, 16'sd12, 16'sd13, 16'sd14, 1'b1);
    tick(1);
    send(16'sd21, 16'sd22, 16'sd23, 16'sd24, 1'b1);
    send(16'sd31, 16'sd32, 16'sd33, 16'sd34, 1'b1);
    bus.out_ready = 1'b1;
    tick(1);
    bus.out_ready = 1'b0;
    check_bit("pre_rst_second", bus.out_second, 1'b1);
    check_val("pre_rst_re", bus.Re_o, 16'sd13);
    #2;
    rst_n = 1'b0;
    #1;
    check_bit("async_rst_valid", bus.out_valid, 1'b0);
    check_bit("async_rst_overflow", bus.overflow, 1'b0);
    check_bit("async_rst_in_ready", bus.in_ready, 1'b1);
    check_bit("async_rst_second", bus.out_second, 1'b0);
    tick(2);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send(16'sd41, -16'sd42, 16'sd43, -16'sd44, 1'b1);
    tick(1);
    check_bit("post_rst_valid", bus.out_valid, 1'b1);
    check_val("post_rst_re", bus.Re_o, 16'sd41);
    tick(1);
    check_val("post_rst_lower_im", bus.Im_o, -16'sd44);
    tick(1);
    check_bit("post_rst_idle", bus.out_valid, 1'b0);

    // Randomized valid/ready with at most D pairs outstanding.
    sent = 0;
    cyc  = 0;
    while (sent < 2000 && cyc < 40000) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0 && ((exp_q.size() + 1) / 2 + 1) <= int'(D)) begin
        send(rnd(), rnd(), rnd(), rnd(), 1'b1);
        sent++;
      end else begin
        tick(1);
      end
      cyc++;
    end
    check_int("rand_pairs_sent", sent, 2000);
    bus.out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 200) begin
      tick(1);
      cyc++;
    end
    check_int("rand_queue_drained", exp_q.size(), 0);
    check_bit("rand_overflow", bus.overflow, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
